// File: rtl/dsm_cifb_mod.sv
// N-th order CIFB delta-sigma modulator with a multi-level mid-tread quantizer,
// optional LFSR dither, saturating integrators and automatic instability recovery.
module dsm_cifb_mod #(
    parameter int          DW         = 20,
    parameter int          FRAC       = 15,
    parameter int          ORDER      = 2,
    parameter int          QBITS      = 2,
    parameter logic [15:0] GAIN_SHIFT = 16'h0000,
    parameter int          SAT_LIMIT  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [DW-1:0]    vin,
    input  logic                    in_valid,
    input  logic                    dither_en,
    input  logic                    clr_ovf,
    output logic signed [QBITS-1:0] code,
    output logic                    out_valid,
    output logic                    ovf,
    output logic                    recovering
);

    localparam int EW  = DW + 2;
    localparam int QSH = FRAC - QBITS + 2;
    localparam int M   = (1 << (QBITS - 1)) - 1;

    localparam logic signed [EW-1:0] STEP = EW'(1 << QSH);
    localparam logic signed [EW-1:0] HALF = STEP >>> 1;
    localparam logic signed [EW-1:0] DSUB = STEP >>> 4;
    localparam logic signed [EW-1:0] QMAX = EW'(M);
    localparam logic signed [EW-1:0] QMIN = -QMAX;
    localparam logic signed [EW-1:0] SMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;

    state_t                 state_q;
    logic signed [DW-1:0]   x_q [ORDER];
    logic signed [QBITS-1:0] code_q;
    logic                   out_valid_q;
    logic                   ovf_q;
    logic                   rec_q;
    logic [7:0]             sat_cnt_q;
    logic [2:0]             rec_cnt_q;
    logic [15:0]            lfsr_q;

    logic signed [DW-1:0]   x_d [ORDER];
    logic signed [QBITS-1:0] code_d;
    logic [7:0]             sat_cnt_d;
    logic [15:0]            lfsr_d;

    logic signed [EW-1:0]   fb_s;
    logic signed [EW-1:0]   src_s [ORDER];
    logic [DW:0]            integ_s [ORDER];
    logic                   clamp_any_s;
    logic                   sat_hit_s;
    logic signed [EW-1:0]   base_s;
    logic signed [EW-1:0]   dith_s;
    logic signed [EW-1:0]   y_s;
    logic signed [EW-1:0]   qv_s;

    // One integrator update: {clamped, value}; the difference is scaled before accumulation.
    function automatic logic [DW:0] integ_step(
        input logic signed [DW-1:0] x,
        input logic signed [EW-1:0] src,
        input logic signed [EW-1:0] fb,
        input logic [3:0]           gsh
    );
        logic signed [EW-1:0] diff;
        logic signed [EW-1:0] sum;
        diff = (src - fb) >>> gsh;
        sum  = {{2{x[DW-1]}}, x} + diff;
        if (sum > SMAX) begin
            integ_step = {1'b1, SMAX[DW-1:0]};
        end else if (sum < SMIN) begin
            integ_step = {1'b1, SMIN[DW-1:0]};
        end else begin
            integ_step = {1'b0, sum[DW-1:0]};
        end
    endfunction

    // Integrator chain next state and the combined clamp indication.
    always_comb begin
        fb_s     = {{(EW-QBITS){code_q[QBITS-1]}}, code_q} <<< QSH;
        src_s[0] = {{2{vin[DW-1]}}, vin};
        for (int k = 1; k < ORDER; k++) begin
            src_s[k] = {{2{x_q[k-1][DW-1]}}, x_q[k-1]};
        end
        clamp_any_s = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            integ_s[k]  = integ_step(x_q[k], src_s[k], fb_s, GAIN_SHIFT[4*k +: 4]);
            x_d[k]      = integ_s[k][DW-1:0];
            clamp_any_s = clamp_any_s | integ_s[k][DW];
        end
    end

    // Dithered quantizer input, floor-shift quantizer with clamp, LFSR and sat counter.
    always_comb begin
        base_s = {{2{x_q[ORDER-1][DW-1]}}, x_q[ORDER-1]};
        dith_s = {{(EW-FRAC+3){lfsr_q[FRAC-4]}}, lfsr_q[FRAC-4:0]} - DSUB;
        if (dither_en) begin
            y_s = base_s + dith_s;
        end else begin
            y_s = base_s;
        end
        qv_s = (y_s + HALF) >>> QSH;
        if (qv_s > QMAX) begin
            code_d = QMAX[QBITS-1:0];
        end else if (qv_s < QMIN) begin
            code_d = QMIN[QBITS-1:0];
        end else begin
            code_d = qv_s[QBITS-1:0];
        end
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (clamp_any_s) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end else begin
            sat_cnt_d = 8'd0;
        end
        sat_hit_s = clamp_any_s && (sat_cnt_q == 8'(SAT_LIMIT - 1));
    end

    // Loop state, RUN/RECOVER control and registered outputs. recovering stays high
    // from the entry sample through all but the last of the ORDER recovery samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            for (int k = 0; k < ORDER; k++) begin
                x_q[k] <= '0;
            end
            code_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            rec_q       <= 1'b0;
            sat_cnt_q   <= 8'd0;
            rec_cnt_q   <= 3'd0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            out_valid_q <= in_valid;
            if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
            if (in_valid) begin
                lfsr_q <= lfsr_d;
                case (state_q)
                    ST_RUN: begin
                        if (clamp_any_s) begin
                            ovf_q <= 1'b1;
                        end
                        if (sat_hit_s) begin
                            for (int k = 0; k < ORDER; k++) begin
                                x_q[k] <= '0;
                            end
                            code_q    <= '0;
                            rec_q     <= 1'b1;
                            sat_cnt_q <= 8'd0;
                            rec_cnt_q <= 3'd0;
                            state_q   <= ST_RECOVER;
                        end else begin
                            for (int k = 0; k < ORDER; k++) begin
                                x_q[k] <= x_d[k];
                            end
                            code_q    <= code_d;
                            sat_cnt_q <= sat_cnt_d;
                        end
                    end
                    ST_RECOVER: begin
                        for (int k = 0; k < ORDER; k++) begin
                            x_q[k] <= '0;
                        end
                        code_q <= '0;
                        if (rec_cnt_q == 3'(ORDER - 1)) begin
                            rec_cnt_q <= 3'd0;
                            sat_cnt_q <= 8'd0;
                            rec_q     <= 1'b0;
                            state_q   <= ST_RUN;
                        end else begin
                            rec_cnt_q <= rec_cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_RUN;
                        rec_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign code       = code_q;
    assign out_valid  = out_valid_q;
    assign ovf        = ovf_q;
    assign recovering = rec_q;

endmodule

// File: tb/tb_dsm_cifb_mod.sv
// Scoreboard bench for dsm_cifb_mod: three parameter sets, directed stimulus,
// expected outputs queued at issue time and popped by a negedge monitor.
module tb_dsm_cifb_mod;

    localparam logic signed [19:0] FS      = 20'sh08000;
    localparam logic signed [19:0] HALF_FS = 20'sh04000;
    localparam logic signed [19:0] ZERO    = 20'sh00000;

    typedef struct packed {
        logic              bound;
        logic signed [3:0] code;
        logic              ovf;
        logic              rec;
    } exp_t;

    logic               clk;
    logic               rst;
    logic signed [19:0] vin_a [3];
    logic [2:0]         iv_v;
    logic [2:0]         de_v;
    logic [2:0]         clr_v;
    logic [2:0]         ov_v;
    logic [2:0]         ovf_v;
    logic [2:0]         rec_v;
    logic signed [1:0]  code1;
    logic signed [1:0]  code2;
    logic signed [2:0]  code3;
    logic signed [3:0]  cw [3];

    int                 checks;
    int                 errors;
    int                 code_sum;
    exp_t               q0[$];
    exp_t               q1[$];
    exp_t               q2[$];
    exp_t               mon_e;
    logic signed [3:0]  last_exp [3];
    logic [2:0]         hold_ok;

    int s2_tab [14] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    dsm_cifb_mod #(.ORDER(1), .QBITS(2)) u_o1q2 (
        .clock(clk), .reset(rst), .vin(vin_a[0]), .in_valid(iv_v[0]),
        .dither_en(de_v[0]), .clr_ovf(clr_v[0]), .code(code1),
        .out_valid(ov_v[0]), .ovf(ovf_v[0]), .recovering(rec_v[0]));

    dsm_cifb_mod #(.ORDER(2), .QBITS(2)) u_o2q2 (
        .clock(clk), .reset(rst), .vin(vin_a[1]), .in_valid(iv_v[1]),
        .dither_en(de_v[1]), .clr_ovf(clr_v[1]), .code(code2),
        .out_valid(ov_v[1]), .ovf(ovf_v[1]), .recovering(rec_v[1]));

    dsm_cifb_mod #(.ORDER(2), .QBITS(3)) u_o2q3 (
        .clock(clk), .reset(rst), .vin(vin_a[2]), .in_valid(iv_v[2]),
        .dither_en(de_v[2]), .clr_ovf(clr_v[2]), .code(code3),
        .out_valid(ov_v[2]), .ovf(ovf_v[2]), .recovering(rec_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cw[0] = 4'(code1);
        cw[1] = 4'(code2);
        cw[2] = 4'(code3);
    end

    function automatic exp_t mk(input logic bnd, input int c, input logic o, input logic r);
        exp_t e;
        e.bound = bnd;
        e.code  = 4'(c);
        e.ovf   = o;
        e.rec   = r;
        return e;
    endfunction

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qlen(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: pop and compare on every out_valid; between outputs the code must hold.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                last_exp[d] = 4'sd0;
                hold_ok[d]  = 1'b1;
            end else if (ov_v[d] === 1'b1) begin
                checks++;
                if (qlen(d) == 0) begin
                    errors++;
                    $display("FAIL unexpected_out dut%0d: got code %0d with out_valid, required no output", d, cw[d]);
                end else begin
                    mon_e = qpop(d);
                    if (mon_e.bound) begin
                        hold_ok[d] = 1'b0;
                        code_sum   = code_sum + int'(cw[d]);
                        if ($isunknown(cw[d]) || cw[d] > 4'sd1 || cw[d] < -4'sd1 ||
                            ovf_v[d] !== mon_e.ovf || rec_v[d] !== mon_e.rec) begin
                            errors++;
                            $display("FAIL dither_bound dut%0d: got code=%0d ovf=%b rec=%b, required |code|<=1 ovf=%b rec=%b",
                                     d, cw[d], ovf_v[d], rec_v[d], mon_e.ovf, mon_e.rec);
                        end
                    end else begin
                        last_exp[d] = mon_e.code;
                        if (cw[d] !== mon_e.code || ovf_v[d] !== mon_e.ovf || rec_v[d] !== mon_e.rec) begin
                            errors++;
                            $display("FAIL sample_out dut%0d @%0t: got code=%0d ovf=%b rec=%b, required code=%0d ovf=%b rec=%b",
                                     d, $time, cw[d], ovf_v[d], rec_v[d], mon_e.code, mon_e.ovf, mon_e.rec);
                        end
                    end
                end
            end else if (hold_ok[d]) begin
                checks++;
                if (cw[d] !== last_exp[d]) begin
                    errors++;
                    $display("FAIL code_hold dut%0d @%0t: got code=%0d, required %0d", d, $time, cw[d], last_exp[d]);
                end
            end
        end
    end

    task automatic sample(input int d, input logic signed [19:0] v, input logic clr,
                          input logic de, input exp_t e);
        vin_a[d] = v;
        iv_v[d]  = 1'b1;
        clr_v[d] = clr;
        de_v[d]  = de;
        push(d, e);
        @(posedge clk);
        #1;
        iv_v[d]  = 1'b0;
        clr_v[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rst(input int d);
        checks++;
        if (ov_v[d] !== 1'b0 || cw[d] !== 4'sd0 || ovf_v[d] !== 1'b0 || rec_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dut%0d @%0t: got ov=%b code=%0d ovf=%b rec=%b, required all 0",
                     d, $time, ov_v[d], cw[d], ovf_v[d], rec_v[d]);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) chk_rst(d);
        end
        rst = 1'b0;
    endtask

    // Position p in the 27-sample cycle of a 2nd-order, 3-level loop driven at +FS:
    // two zeros, 22 ones (clamping from p=9), entry into recovery at p=24, two more zeros.
    function automatic exp_t fs_exp(input int i);
        int p;
        p = i % 27;
        return mk(1'b0, (p >= 2 && p <= 23) ? 1 : 0, (i >= 9) ? 1'b1 : 1'b0,
                  (p == 24 || p == 25) ? 1'b1 : 1'b0);
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        code_sum = 0;
        hold_ok  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            last_exp[d] = 4'sd0;
            vin_a[d]    = FS;
        end
        iv_v  = 3'b111;
        de_v  = 3'b000;
        clr_v = 3'b000;
        rst   = 1'b1;

        // Reset held three cycles with strobes active.
        do_reset(3);
        iv_v = 3'b000;
        idle(1);

        // ORDER=1, 0.5 FS, strobe every cycle.
        for (int i = 0; i < 14; i++) sample(0, HALF_FS, 1'b0, 1'b0, mk(1'b0, s2_tab[i], 1'b0, 1'b0));
        idle(2);
        do_reset(1);

        // Same sequence with one-cycle gaps between strobes.
        for (int i = 0; i < 14; i++) begin
            sample(0, HALF_FS, 1'b0, 1'b0, mk(1'b0, s2_tab[i], 1'b0, 1'b0));
            idle(1);
        end

        // ORDER=2 at +FS: saturation, sticky ovf, recovery; clr_ovf during a clamp.
        for (int i = 0; i < 216; i++) sample(1, FS, (i == 200) ? 1'b1 : 1'b0, 1'b0, fs_exp(i));
        // Clean state after recovery: clr_ovf with vin = 0 clears the flag.
        sample(1, ZERO, 1'b1, 1'b0, mk(1'b0, 0, 1'b0, 1'b0));
        sample(1, ZERO, 1'b0, 1'b0, mk(1'b0, 0, 1'b0, 1'b0));
        idle(2);

        // QBITS=3 with dither, zero input.
        for (int i = 0; i < 1024; i++) sample(2, ZERO, 1'b0, 1'b1, mk(1'b1, 0, 1'b0, 1'b0));
        idle(2);

        // Drive into RECOVER again, then reset in the middle of it.
        for (int i = 0; i < 25; i++) sample(1, FS, 1'b0, 1'b0, fs_exp(i));
        idle(2);
        rst      = 1'b1;
        iv_v[1]  = 1'b1;
        vin_a[1] = FS;
        @(posedge clk);
        #1;
        chk_rst(1);
        rst     = 1'b0;
        iv_v[1] = 1'b0;
        idle(4);

        for (int d = 0; d < 3; d++) begin
            checks++;
            if (qlen(d) != 0) begin
                errors++;
                $display("FAIL missing_outputs dut%0d: got %0d outputs still pending, required 0", d, qlen(d));
            end
        end
        checks++;
        if (code_sum > 4 || code_sum < -4) begin
            errors++;
            $display("FAIL dither_sum: got sum %0d, required within +/-4", code_sum);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
